// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance counter bank:
// register codes, CFG bit positions and the per-counter configuration struct.
package hpm_pkg;

    localparam logic [1:0] HPM_CNT_LO = 2'd0;
    localparam logic [1:0] HPM_CNT_HI = 2'd1;
    localparam logic [1:0] HPM_CFG    = 2'd2;
    localparam logic [1:0] HPM_STATUS = 2'd3;

    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_IRQ_BIT = 1;
    localparam int CFG_FRZ_BIT = 2;
    localparam int CFG_EVT_LSB = 8;

    // Sized for the largest event vector (32); bits above EVT_SEL_W stay zero.
    localparam int EVT_SEL_MAX_W = 5;

    typedef struct packed {
        logic [EVT_SEL_MAX_W-1:0] evt_sel;
        logic                     frz_gate;
        logic                     irq_en;
        logic                     en;
    } hpm_cfg_t;

endpackage

// File: rtl/hpm_counter_slice.sv
// One event counter with its CFG and sticky overflow flag.
// Priority: CSR count write > increment; overflow set > W1C clear.
module hpm_counter_slice
    import hpm_pkg::*;
#(
    parameter int CNT_W     = 64,
    parameter int NUM_EVT   = 8,
    parameter int EVT_SEL_W = 3
) (
    input  logic               proc_clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic [NUM_EVT-1:0] event_vec,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic               wr_cfg,
    input  logic               wr_status,
    input  logic [31:0]        wrdata,
    output logic [CNT_W-1:0]   count,
    output hpm_cfg_t           cfg,
    output logic               ovf
);

    logic [31:0]      evt_pad;
    logic             evt_hit;
    logic             inc;
    logic             wrap;
    logic [63:0]      cnt_wr;
    logic [CNT_W-1:0] count_next;
    hpm_cfg_t         cfg_next;
    logic             ovf_next;

    always_comb begin
        evt_pad = 32'(event_vec);
        // Selectors beyond the event vector match nothing, so the counter holds.
        evt_hit = (int'(cfg.evt_sel) < NUM_EVT) && evt_pad[cfg.evt_sel];
        inc     = cfg.en && evt_hit && !(cfg.frz_gate && freeze);
        wrap    = inc && (count == '1) && !(wr_lo || wr_hi);

        // Writes go through a 64-bit view so narrow counters simply drop upper bits.
        cnt_wr = 64'(count);
        if (wr_lo) cnt_wr[31:0]  = wrdata;
        if (wr_hi) cnt_wr[63:32] = wrdata;

        if (wr_lo || wr_hi) count_next = cnt_wr[CNT_W-1:0];
        else if (inc)       count_next = count + CNT_W'(1);
        else                count_next = count;

        cfg_next = cfg;
        if (wr_cfg) begin
            cfg_next.en       = wrdata[CFG_EN_BIT];
            cfg_next.irq_en   = wrdata[CFG_IRQ_BIT];
            cfg_next.frz_gate = wrdata[CFG_FRZ_BIT];
            cfg_next.evt_sel  = EVT_SEL_MAX_W'(wrdata[CFG_EVT_LSB +: EVT_SEL_W]);
        end

        ovf_next = ovf;
        if (wr_status && wrdata[0]) ovf_next = 1'b0;
        if (wrap)                   ovf_next = 1'b1;
    end

    always_ff @(posedge proc_clk) begin
        if (rst) begin
            count <= '0;
            cfg   <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            cfg   <= cfg_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CNT event counters behind a CSR read/write port with overflow irq.
// Optional coherent HI read via a shared shadow register: define HPM_SNAPSHOT_EN.
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int NUM_CNT   = 4,
    parameter int CNT_W     = 64,
    parameter int NUM_EVT   = 8,
    parameter int EVT_SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1,
    parameter int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic               proc_clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic [NUM_EVT-1:0] event_vec,
    input  logic [IDX_W+1:0]   csr_rd_sel,
    output logic [31:0]        csr_rd_data,
    input  logic               csr_wr_en,
    input  logic [IDX_W+1:0]   csr_wr_sel,
    input  logic [31:0]        csr_wrdata,
    output logic               ovf_irq
);

    // CSR handshake: a write takes effect at the edge where csr_wr_en is high
    // (no ready, never stalls); csr_rd_data shows the register selected by
    // csr_rd_sel at the previous edge, and holds while freeze is high.
    localparam int NUM_SLOT = 2 ** IDX_W;

    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_reg;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_reg;

    logic [63:0]         cnt_ext [NUM_SLOT];
    logic [31:0]         cfg_wd  [NUM_SLOT];
    logic [NUM_SLOT-1:0] ovf_vec;
    logic [NUM_SLOT-1:0] irq_vec;
    logic [31:0]         hi_word;
    logic [31:0]         rd_mux;

    assign wr_idx = csr_wr_sel[IDX_W+1:2];
    assign wr_reg = csr_wr_sel[1:0];
    assign rd_idx = csr_rd_sel[IDX_W+1:2];
    assign rd_reg = csr_rd_sel[1:0];

    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
        if (i < NUM_CNT) begin : g_cnt
            logic             hit;
            logic [CNT_W-1:0] count;
            hpm_cfg_t         cfg;
            logic             ovf;

            assign hit = csr_wr_en && (wr_idx == IDX_W'(i));

            hpm_counter_slice #(
                .CNT_W     (CNT_W),
                .NUM_EVT   (NUM_EVT),
                .EVT_SEL_W (EVT_SEL_W)
            ) u_slice (
                .proc_clk  (proc_clk),
                .rst       (rst),
                .freeze    (freeze),
                .event_vec (event_vec),
                .wr_lo     (hit && (wr_reg == HPM_CNT_LO)),
                .wr_hi     (hit && (wr_reg == HPM_CNT_HI)),
                .wr_cfg    (hit && (wr_reg == HPM_CFG)),
                .wr_status (hit && (wr_reg == HPM_STATUS)),
                .wrdata    (csr_wrdata),
                .count     (count),
                .cfg       (cfg),
                .ovf       (ovf)
            );

            assign cnt_ext[i] = 64'(count);
            assign cfg_wd[i]  = {19'd0, cfg.evt_sel, 5'd0, cfg.frz_gate, cfg.irq_en, cfg.en};
            assign ovf_vec[i] = ovf;
            assign irq_vec[i] = cfg.irq_en;
        end else begin : g_empty
            // Unpopulated index slots read as zero and never interrupt.
            assign cnt_ext[i] = '0;
            assign cfg_wd[i]  = '0;
            assign ovf_vec[i] = 1'b0;
            assign irq_vec[i] = 1'b0;
        end
    end

`ifdef HPM_SNAPSHOT_EN
    logic [31:0]      shadow_hi;
    logic [IDX_W-1:0] shadow_idx;
    logic             shadow_vld;

    always_ff @(posedge proc_clk) begin
        if (rst) begin
            shadow_hi  <= '0;
            shadow_idx <= '0;
            shadow_vld <= 1'b0;
        end else if (!freeze && (rd_reg == HPM_CNT_LO)) begin
            shadow_hi  <= cnt_ext[rd_idx][63:32];
            shadow_idx <= rd_idx;
            shadow_vld <= 1'b1;
        end
    end

    assign hi_word = (shadow_vld && (shadow_idx == rd_idx)) ? shadow_hi : cnt_ext[rd_idx][63:32];
`else
    assign hi_word = cnt_ext[rd_idx][63:32];
`endif

    always_comb begin
        rd_mux = '0;
        case (rd_reg)
            HPM_CNT_LO: rd_mux = cnt_ext[rd_idx][31:0];
            HPM_CNT_HI: rd_mux = hi_word;
            HPM_CFG:    rd_mux = cfg_wd[rd_idx];
            HPM_STATUS: rd_mux = {31'd0, ovf_vec[rd_idx]};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge proc_clk) begin
        if (rst) begin
            csr_rd_data <= '0;
            ovf_irq     <= 1'b0;
        end else begin
            if (!freeze) csr_rd_data <= rd_mux;
            ovf_irq <= |(ovf_vec & irq_vec);
        end
    end

endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
- Parametrised bank of NUM_CNT general-purpose event counters; successor to the fixed cycle/instret/time counter block.
- Each counter has its own event selector, enable and overflow interrupt; a sticky overflow status is cleared by writing 1.
- Sits beside the CSR unit: reads are registered, and writes come through the CSR write port.

Parameters:
- NUM_CNT, 4, number of counters (1..16).
- CNT_W, 64, counter width (32..64).
- NUM_EVT, 8, width of the event input vector (2..32).
- EVT_SEL_W, $clog2(NUM_EVT), width of the event-select field (derived).
- IDX_W, $clog2(NUM_CNT) (minimum 1), counter index width (derived).

Ports:
- proc_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  pipeline freeze; gates counting only where cfg.frz_gate=1, and holds csr_rd_data.
- event_vec  in  NUM_EVT  one-cycle event pulses; bit 0 is tied high by the integrator (cycle event).
- csr_rd_sel  in  IDX_W+2  read select: {index, reg}.
- csr_rd_data  out  32  registered read data.
- csr_wr_en  in  1  write strobe.
- csr_wr_sel  in  IDX_W+2  write select: {index, reg}.
- csr_wrdata  in  32  write data.
- ovf_irq  out  1  OR over all counters of (ovf & irq_en), registered.

Behaviour:
- Register codes (reg field):
  - 0 CNT_LO: count[31:0].
  - 1 CNT_HI: count[CNT_W-1:32], zero-extended.
  - 2 CFG: [0] en, [1] irq_en, [2] frz_gate, [8 +: EVT_SEL_W] evt_sel.
  - 3 STATUS: [0] ovf.
- Reset:
  - All counts = 0, CFG = 0, ovf = 0.
  - csr_rd_data = 0, ovf_irq = 0.
- Increment condition for counter i, evaluated each cycle:
  - en && event_vec[evt_sel] && !(frz_gate && freeze).
  - Adds exactly 1; no multi-event accumulation.
- Wrap: count == all-ones plus an increment → count = 0, ovf set the same edge; ovf_irq asserts one cycle later.
- Writes:
  - CNT_LO/CNT_HI replace the addressed half.
  - A CSR write beats a same-cycle increment of that counter: the increment is dropped and the other half is held.
  - CNT_W == 32: CNT_HI writes are ignored and CNT_HI reads return 0.
  - CNT_W between 33 and 63: unused upper bits of CNT_HI are dropped on write and read as 0.
- evt_sel >= NUM_EVT selects no event, so the counter holds.
- STATUS writes are W1C on bit 0. If a wrap and a W1C clear land in the same cycle, set wins and ovf stays 1.
- Writing count to a nonzero value does not touch ovf.
- Read path:
  - csr_rd_data <= mux(csr_rd_sel) at each edge unless freeze; 1-cycle latency.
  - index >= NUM_CNT reads 0.
- Reading never stalls counting; this deliberately differs from the predecessor.
- rst mid-operation: every register returns to its reset value at the next edge. No partial state survives.
- ovf_irq is level, not a pulse; it stays high until every offending ovf is cleared or its irq_en is cleared.

Optional Feature:
- Macro: HPM_SNAPSHOT_EN.
- Defined:
  - A CNT_LO read of counter i captures count[CNT_W-1:32] of that counter into a single shared shadow register, in the same cycle as the LO sample.
  - A later CNT_HI read of the same index returns the shadow, giving a coherent 64-bit read across a carry.
  - A CNT_HI read of a different index returns the live value.
  - Shadow resets to 0.
- Not defined: CNT_HI always reads live, and no shadow register exists.

Decomposition:
- Package hpm_pkg:
  - Register-code constants HPM_CNT_LO/HI/CFG/STATUS.
  - CFG bit positions (CFG_EN_BIT, CFG_IRQ_BIT, CFG_FRZ_BIT, CFG_EVT_LSB).
  - The cfg struct typedef.
- Sub-module hpm_counter_slice: one counter, its CFG and ovf flag, and its write/increment/wrap priority logic.
- Top level: generate loop over slices, write decode, read mux, irq OR, and optional shadow.

Test Plan:
- Reset, then CFG0 = 0x001 (en, evt 0) for 10 cycles → read CNT_LO0 = 10, CNT_HI0 = 0, ovf_irq = 0.
- Write CNT_LO1 = 0xFFFFFFFF and CNT_HI1 = 0xFFFFFFFF, set CFG1 = 0x003, pulse event 0 → count wraps to 0, STATUS1 = 1, ovf_irq = 1 next cycle; W1C STATUS1 = 1 → ovf_irq = 0.
- CFG2 evt_sel = 3 with event_vec[3] pulsed 5 times, freeze high for 3 cycles, frz_gate = 1 → CNT_LO2 = 5; repeat with frz_gate = 0 and event 0 → frozen cycles are counted.
- Write CNT_LO0 = 0x1234 in a cycle where it would increment → reads 0x1234, not 0x1235. Wrap coinciding with a W1C → STATUS stays 1.
- HPM_SNAPSHOT_EN: set count3 = 0x0000_0000_FFFF_FFFF, read LO the cycle before the carry, then read HI → HI = 0 (shadow); without the macro → HI = 1.
- Assert rst mid-count with CFG written → next cycle all reads return 0 and ovf_irq = 0; read of index >= NUM_CNT (NUM_CNT = 3) → 0.
